prio_enc_drain: RTL and testbench

PRIO_ENC_DRAIN -- requirements
Module: prio_enc_drain

---
 rtl/prio_enc_drain.sv | 129 ++++++++++++
 tb/tb_prio_enc_drain.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_drain.sv
// Priority-encodes an accepted request vector and drains its set bits one index per handshake.
// Latency: first index valid 1 cycle after accepting a non-zero vector; then 1 index/cycle.
// Backpressure: out_idx/out_last hold while out_ready=0; in_ready is low for the whole drain.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     - vector handshake; in_data is the N-bit request vector
//   out_valid/out_ready   - index handshake; out_idx is the selected bit, out_last marks the final one
//   zero_drop             - one-cycle pulse after an all-zero vector is accepted (nothing is emitted)
//
// Build option: define PRIO_MSB_FIRST_EN to drain highest index first; default is lowest first.
module prio_enc_drain #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_drop
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t       state_q,     state_d;
  logic [N-1:0] pending_q,   pending_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q,  in_ready_d;
  logic         zero_drop_q, zero_drop_d;

  logic         accept;
  logic         out_fire;
  logic         one_left;
  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_mask;

  // Selection order: later loop iterations overwrite earlier ones, so the
  // loop direction decides which set bit wins.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
`ifdef PRIO_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
`endif
    return r;
  endfunction

  always_comb begin
    accept   = in_valid && in_ready_q;
    out_fire = out_valid_q && out_ready;
    sel_idx  = pick(pending_q);
    sel_mask = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    one_left = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

    state_d     = state_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    zero_drop_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = in_data;
          if (in_data != '0) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // in_valid/in_data are deliberately not looked at here.
        if (out_fire) begin
          pending_d = pending_q & ~sel_mask;
          if (one_left) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        pending_d   = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // pending is cleared by reset and empty in IDLE, so out_idx reads 0 there.
  assign out_idx   = sel_idx;
  assign out_last  = out_valid_q && one_left;
  assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_prio_enc_drain.sv
module tb_prio_enc_drain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       zero_drop;

  int tests_run    = 0;
  int tests_failed = 0;

  prio_enc_drain #(.N(8), .W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_drop (zero_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for one edge, then withdraw it.
  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 ||
        out_last !== 1'b0 || zero_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: vld=%b rdy=%b idx=%0d last=%b zd=%b, want 0 1 0 0 0",
               out_valid, in_ready, out_idx, out_last, zero_drop);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_drain_basic();
    logic [2:0] exp [3];
`ifdef PRIO_MSB_FIRST_EN
    exp = '{3'd5, 3'd2, 3'd0};
`else
    exp = '{3'd0, 3'd2, 3'd5};
`endif
    out_ready = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_rdy_before: in_ready=%b, want 1", in_ready);
    end
    send(8'b00100101);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== exp[i] || out_last !== (i == 2) || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_idx%0d: vld=%b idx=%0d last=%b rdy=%b, want 1 %0d %b 0",
                 i, out_valid, out_idx, out_last, in_ready, exp[i], (i == 2));
      end
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_end: vld=%b rdy=%b last=%b, want 0 1 0", out_valid, in_ready, out_last);
    end
  endtask

  task automatic test_two_bits();
    logic [2:0] exp [2];
`ifdef PRIO_MSB_FIRST_EN
    exp = '{3'd5, 3'd0};
`else
    exp = '{3'd0, 3'd5};
`endif
    out_ready = 1'b1;
    send(8'b00100001);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== exp[i] || out_last !== (i == 1)) begin
        tests_failed++;
        $display("FAIL two_bits_idx%0d: vld=%b idx=%0d last=%b, want 1 %0d %b",
                 i, out_valid, out_idx, out_last, exp[i], (i == 1));
      end
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL two_bits_end: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] first, second;
`ifdef PRIO_MSB_FIRST_EN
    first = 3'd7; second = 3'd1;
`else
    first = 3'd1; second = 3'd7;
`endif
    out_ready = 1'b0;
    send(8'b10000010);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== first || out_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: vld=%b idx=%0d last=%b, want 1 %0d 0",
                 i, out_valid, out_idx, out_last, first);
      end
      step();
    end
    out_ready = 1'b1;
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== first || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_first: vld=%b idx=%0d last=%b, want 1 %0d 0", out_valid, out_idx, out_last, first);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== second || out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_second: vld=%b idx=%0d last=%b, want 1 %0d 1", out_valid, out_idx, out_last, second);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_end: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_vector();
    out_ready = 1'b1;
    send(8'h00);
    tests_run++;
    if (zero_drop !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_pulse: zd=%b vld=%b rdy=%b, want 1 0 1", zero_drop, out_valid, in_ready);
    end
    step();
    tests_run++;
    if (zero_drop !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_after: zd=%b vld=%b rdy=%b, want 0 0 1", zero_drop, out_valid, in_ready);
    end
  endtask

  task automatic test_drain_input();
    logic [2:0] ff_idx [8];
`ifdef PRIO_MSB_FIRST_EN
    ff_idx = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
`else
    ff_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    out_ready = 1'b0;
    send(8'b00000001);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b1) begin
        tests_failed++;
        $display("FAIL drain_in_hold%0d: rdy=%b vld=%b idx=%0d last=%b, want 0 1 0 1",
                 i, in_ready, out_valid, out_idx, out_last);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_in_idle: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== ff_idx[i] || out_last !== (i == 7)) begin
        tests_failed++;
        $display("FAIL ff_idx%0d: vld=%b idx=%0d last=%b, want 1 %0d %b",
                 i, out_valid, out_idx, out_last, ff_idx[i], (i == 7));
      end
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ff_end: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] exp [2];
`ifdef PRIO_MSB_FIRST_EN
    exp = '{3'd7, 3'd6};
`else
    exp = '{3'd4, 3'd5};
`endif
    out_ready = 1'b1;
    send(8'b11110000);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== exp[i]) begin
        tests_failed++;
        $display("FAIL mr_idx%0d: vld=%b idx=%0d, want 1 %0d", i, out_valid, out_idx, exp[i]);
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL mr_async: vld=%b rdy=%b idx=%0d last=%b, want 0 1 0 0",
               out_valid, in_ready, out_idx, out_last);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL mr_after%0d: vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Single-bit vector: one index, then a second vector accepted straight after.
    out_ready = 1'b1;
    send(8'b00001000);
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: vld=%b idx=%0d last=%b, want 1 3 1", out_valid, out_idx, out_last);
    end
    step();
    send(8'b01000000);
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 3'd6 || out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second: vld=%b idx=%0d last=%b, want 1 6 1", out_valid, out_idx, out_last);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_end: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_drain_basic();
    test_two_bits();
    test_backpressure();
    test_zero_vector();
    test_drain_input();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
